// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: x - y - bi.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   always_comb begin
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - b_in, LSB first, with start/busy/done handshake.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int unsigned      CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic [CNT_W-1:0] cnt;
   logic             brw;
   logic             fs_d;
   logic             fs_bo;

   full_subtractor u_fs (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .bi (brw),
      .d  (fs_d),
      .bo (fs_bo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         d_sh   <= '0;
         cnt    <= '0;
         brw    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  brw   <= b_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_sh <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh <= {1'b0, b_sh[WIDTH-1:1]};
               d_sh <= {fs_d, d_sh[WIDTH-1:1]};
               brw  <= fs_bo;
               cnt  <= cnt + CNT_W'(1);
               // Last bit: results capture the combinational cell output directly.
               if (cnt == LAST) begin
                  diff   <= {fs_d, d_sh[WIDTH-1:1]};
                  borrow <= fs_bo;
                  ovf    <= brw ^ fs_bo;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
